inst_mem_prog: RTL and testbench
================================

// Module: inst_mem_prog
// PURPOSE
//  Parametrised, synchronous instruction memory for the RISC-V core. It replaces the
//  combinational fetch ROM with a registered fetch port that has stall hold and fault flags.
//  It also has a streaming program-load port, so test programs are written at run time
//  instead of being hard-coded.
//  Sits between the PC/fetch stage and the decode stage.
// PARAMETERS
//  DATA_W   32            instruction width (bits)
//  DEPTH    64            number of instruction words (need not be a power of two)
//  PC_W     32            width of the byte-addressed PC
//  NOP      32'h00000013  instruction driven on reset, fault, or when no fetch is valid
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous, active-high reset
//  fetch_req    in   1       fetch request, sampled when fetch_stall=0
//  fetch_pc     in   PC_W    byte address of the instruction to fetch
//  fetch_stall  in   1       1 = hold every fetch_* output and ignore fetch_req
//  fetch_valid  out  1       fetch_inst/fetch_err are valid
//  fetch_inst   out  DATA_W  fetched instruction
//  fetch_err    out  1       fault: misaligned or out-of-range PC
//  prog_start   in   1       begin a program load (honoured only in RUN)
//  prog_valid   in   1       prog_data is valid
//  prog_data    in   DATA_W  instruction word to write
//  prog_last    in   1       marks the final word of the load (qualified by prog_valid)
//  prog_ready   out  1       1 in PROG: the load port accepts a word
//  prog_done    out  1       one-cycle pulse: the load has finished
// BEHAVIOUR
//  Reset (sync, rst=1 at a clk edge):
//   - fetch_valid=0, fetch_inst=NOP, fetch_err=0, prog_ready=0, prog_done=0.
//   - state=RUN, write pointer wp=0.
//   - Memory contents are NOT cleared.
//  FSM, two states:
//   - RUN -> PROG when prog_start=1.
//   - PROG -> RUN after a load completes.
//  RUN, fetch_stall=0:
//   - Fetch latency is 1 cycle: fetch_req=1 at edge N gives fetch_valid=1 from edge N+1.
//   - Word index idx = fetch_pc >> 2. A fault occurs if fetch_pc[1:0]!=0 or idx>=DEPTH.
//   - No fault: fetch_inst=mem[idx], fetch_err=0.
//   - Fault: fetch_inst=NOP, fetch_err=1, fetch_valid=1.
//   - fetch_req=0: fetch_valid=0 and fetch_inst=NOP on the next edge.
//  fetch_stall=1 (any state):
//   - fetch_valid, fetch_inst and fetch_err hold their values.
//   - fetch_req is dropped, not queued.
//  Entering PROG:
//   - wp=0 and prog_ready=1 from the next cycle.
//   - fetch_valid=0 and fetch_inst=NOP while in PROG (unless stalled, in which case outputs hold).
//   - fetch_req is ignored while in PROG.
//  PROG:
//   - Each cycle with prog_valid && prog_ready writes mem[wp]=prog_data and then wp++.
//   - The load ends when the accepted word has prog_last=1, or when wp==DEPTH-1 (memory full).
//   - On the ending edge: state=RUN, prog_ready=0, prog_done=1 for exactly one cycle.
//   - Words offered after the end are not accepted and do not wrap: mem[0] stays intact.
//  Simultaneous events:
//   - prog_start and fetch_req together in RUN: the load wins, and fetch_valid is 0 next cycle.
//   - prog_start while in PROG: ignored, wp is not reset.
//   - A fetch the cycle after prog_done returns the newly written data (write-before-read).
//  Reset during PROG: returns to RUN. Words already written remain, and prog_done is not pulsed.
//  Width rules:
//   - wp is $clog2(DEPTH) bits.
//   - The idx compare uses the full PC_W-2 bits, so high PC bits cannot alias onto low words.
// TESTING
//  1. Load 13 words with prog_last on word 12, then fetch PC=0,4,..,48
//     -> each word returned 1 cycle after its request; prog_done pulses once.
//  2. fetch_pc=0x002 and fetch_pc=0x100 (DEPTH=64)
//     -> fetch_valid=1, fetch_err=1, fetch_inst=0x00000013.
//  3. Fetch PC=8 then PC=12 while holding fetch_stall=1 for 3 cycles
//     -> outputs hold mem[2]; mem[3] appears 1 cycle after the stall releases.
//  4. Offer 70 words without prog_last (DEPTH=64)
//     -> exactly 64 written; prog_done after word 63; mem[0] intact.
//  5. rst after 5 of 10 load words
//     -> RUN, no prog_done, mem[0..4] updated, mem[5..] unchanged, outputs at reset values.
//  6. prog_start and fetch_req in the same cycle
//     -> fetch_valid=0 next cycle and prog_ready=1.

Source files
------------

// File: rtl/inst_mem_prog.sv
`default_nettype none
// ============================================================================
//  Module      : inst_mem_prog
//  Description : Synchronous instruction memory with a registered fetch port
//                (1-cycle latency, stall hold, fault flag) and a streaming
//                program-load port used to write test programs at run time.
//                It sits between the PC/fetch stage and the decode stage.
//  Ports       : clk, rst                      - clock, sync active-high reset
//                fetch_req_i, fetch_pc_i       - fetch request and byte PC
//                fetch_stall_i                 - hold all fetch outputs
//                fetch_valid_o, fetch_inst_o,
//                fetch_err_o                   - fetch result
//                prog_start_i                  - enter load mode (RUN only)
//                prog_valid_i, prog_data_i,
//                prog_last_i                   - load word stream
//                prog_ready_o                  - load port accepts a word
//                prog_done_o                   - one-cycle load-finished pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_mem_prog #(
   parameter int          DATA_W = 32,
   parameter int          DEPTH  = 64,
   parameter int          PC_W   = 32,
   parameter logic [DATA_W-1:0] NOP = 32'h00000013
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req_i,
   input  logic [PC_W-1:0]   fetch_pc_i,
   input  logic              fetch_stall_i,
   output logic              fetch_valid_o,
   output logic [DATA_W-1:0] fetch_inst_o,
   output logic              fetch_err_o,
   input  logic              prog_start_i,
   input  logic              prog_valid_i,
   input  logic [DATA_W-1:0] prog_data_i,
   input  logic              prog_last_i,
   output logic              prog_ready_o,
   output logic              prog_done_o
);

   localparam int               c_aw        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [c_aw-1:0]  c_wp_last   = c_aw'(DEPTH - 1);
   localparam logic [PC_W-3:0]  c_depth_idx = (PC_W - 2)'(DEPTH);

   typedef enum logic [0:0] {
      S_RUN  = 1'b0,
      S_PROG = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [c_aw-1:0]     wp_q, wp_d;
   logic                valid_q, valid_d;
   logic [DATA_W-1:0]   inst_q, inst_d;
   logic                err_q, err_d;
   logic                done_q, done_d;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic                w_we;
   logic [PC_W-3:0]     w_idx;
   logic                w_fault;
   logic [c_aw-1:0]     w_rd_addr;

   // The range check uses every word-index bit so that high PC bits never
   // alias onto low memory words.
   assign w_idx     = fetch_pc_i[PC_W-1:2];
   assign w_fault   = (fetch_pc_i[1:0] != 2'b00) || (w_idx >= c_depth_idx);
   assign w_rd_addr = w_idx[c_aw-1:0];

   always_comb begin
      state_d = state_q;
      wp_d    = wp_q;
      done_d  = 1'b0;
      valid_d = valid_q;
      inst_d  = inst_q;
      err_d   = err_q;
      w_we    = 1'b0;

      case (state_q)
         S_RUN: begin
            if (prog_start_i) begin
               state_d = S_PROG;
               wp_d    = '0;
            end
         end
         S_PROG: begin
            if (prog_valid_i) begin
               w_we = 1'b1;
               wp_d = wp_q + 1'b1;
               // A full memory ends the load so later words cannot wrap
               // around and overwrite word 0.
               if (prog_last_i || (wp_q == c_wp_last)) begin
                  state_d = S_RUN;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_RUN;
         end
      endcase

      // Stall freezes the fetch outputs in every state and drops the request.
      // A request coinciding with prog_start loses to the load.
      if (!fetch_stall_i) begin
         if ((state_q == S_RUN) && !prog_start_i && fetch_req_i) begin
            valid_d = 1'b1;
            if (w_fault) begin
               inst_d = NOP;
               err_d  = 1'b1;
            end else begin
               inst_d = mem[w_rd_addr];
               err_d  = 1'b0;
            end
         end else begin
            valid_d = 1'b0;
            inst_d  = NOP;
            err_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RUN;
         wp_q    <= '0;
         valid_q <= 1'b0;
         inst_q  <= NOP;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wp_q    <= wp_d;
         valid_q <= valid_d;
         inst_q  <= inst_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   // Memory contents survive reset; a write offered in the reset cycle is
   // discarded so an aborted load keeps only the words accepted before it.
   always_ff @(posedge clk) begin
      if (!rst && w_we) begin
         mem[wp_q] <= prog_data_i;
      end
   end

   assign fetch_valid_o = valid_q;
   assign fetch_inst_o  = inst_q;
   assign fetch_err_o   = err_q;
   assign prog_ready_o  = (state_q == S_PROG);
   assign prog_done_o   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_prog.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_mem_prog
//  Description : Directed self-checking bench for inst_mem_prog (DEPTH=64).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_mem_prog;

   localparam logic [31:0] c_nop = 32'h00000013;

   logic        clk;
   logic        rst;
   logic        fetch_req;
   logic [31:0] fetch_pc;
   logic        fetch_stall;
   logic        fetch_valid;
   logic [31:0] fetch_inst;
   logic        fetch_err;
   logic        prog_start;
   logic        prog_valid;
   logic [31:0] prog_data;
   logic        prog_last;
   logic        prog_ready;
   logic        prog_done;

   int n_checks;
   int n_errors;
   int done_cnt;
   int done_idx;

   inst_mem_prog #(
      .DATA_W (32),
      .DEPTH  (64),
      .PC_W   (32),
      .NOP    (32'h00000013)
   ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .fetch_req_i   (fetch_req),
      .fetch_pc_i    (fetch_pc),
      .fetch_stall_i (fetch_stall),
      .fetch_valid_o (fetch_valid),
      .fetch_inst_o  (fetch_inst),
      .fetch_err_o   (fetch_err),
      .prog_start_i  (prog_start),
      .prog_valid_i  (prog_valid),
      .prog_data_i   (prog_data),
      .prog_last_i   (prog_last),
      .prog_ready_o  (prog_ready),
      .prog_done_o   (prog_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, act, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled and inputs changed 1 ns
   // after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_chk(input string tag, input logic [31:0] pc, input logic [31:0] exp);
      fetch_req = 1'b1;
      fetch_pc  = pc;
      tick();
      check({tag, "_valid"}, 32'(fetch_valid), 32'd1);
      check({tag, "_err"},   32'(fetch_err),   32'd0);
      check({tag, "_inst"},  fetch_inst,       exp);
      fetch_req = 1'b0;
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      rst         = 1'b1;
      fetch_req   = 1'b0;
      fetch_pc    = '0;
      fetch_stall = 1'b0;
      prog_start  = 1'b0;
      prog_valid  = 1'b0;
      prog_data   = '0;
      prog_last   = 1'b0;
      tick();
      tick();

      // Reset state
      check("rst_valid", 32'(fetch_valid), 32'd0);
      check("rst_inst",  fetch_inst,       c_nop);
      check("rst_err",   32'(fetch_err),   32'd0);
      check("rst_ready", 32'(prog_ready),  32'd0);
      check("rst_done",  32'(prog_done),   32'd0);
      rst = 1'b0;
      tick();

      // 1: load 13 words, last on word 12, then fetch them back
      prog_start = 1'b1;
      tick();
      prog_start = 1'b0;
      check("t1_ready", 32'(prog_ready), 32'd1);
      done_cnt = 0;
      for (int i = 0; i < 13; i++) begin
         prog_valid = 1'b1;
         prog_data  = 32'hA000_0000 + 32'(i);
         prog_last  = (i == 12);
         tick();
         if (prog_done) done_cnt++;
      end
      prog_valid = 1'b0;
      prog_last  = 1'b0;
      check("t1_ready_end", 32'(prog_ready), 32'd0);
      check("t1_done_last", 32'(prog_done),  32'd1);
      // First fetch issued in the cycle right after prog_done
      for (int i = 0; i < 13; i++) begin
         fetch_chk("t1_fetch", 32'(4 * i), 32'hA000_0000 + 32'(i));
         if (prog_done) done_cnt++;
      end
      check("t1_done_cnt", 32'(done_cnt), 32'd1);

      // 2: faults
      fetch_req = 1'b1;
      fetch_pc  = 32'h0000_0002;
      tick();
      check("t2_mis_valid", 32'(fetch_valid), 32'd1);
      check("t2_mis_err",   32'(fetch_err),   32'd1);
      check("t2_mis_inst",  fetch_inst,       c_nop);
      fetch_pc = 32'h0000_0100;
      tick();
      check("t2_oor_valid", 32'(fetch_valid), 32'd1);
      check("t2_oor_err",   32'(fetch_err),   32'd1);
      check("t2_oor_inst",  fetch_inst,       c_nop);
      fetch_pc = 32'h8000_0000;
      tick();
      check("t2_alias_err",  32'(fetch_err), 32'd1);
      check("t2_alias_inst", fetch_inst,     c_nop);
      fetch_pc = 32'h0000_00FC;
      tick();
      check("t2_top_err", 32'(fetch_err), 32'd0);
      fetch_req = 1'b0;
      tick();
      check("t2_idle_valid", 32'(fetch_valid), 32'd0);
      check("t2_idle_inst",  fetch_inst,       c_nop);

      // 3: stall hold
      fetch_chk("t3_pc8", 32'd8, 32'hA000_0002);
      fetch_req   = 1'b1;
      fetch_pc    = 32'd12;
      fetch_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t3_hold_valid", 32'(fetch_valid), 32'd1);
         check("t3_hold_inst",  fetch_inst,       32'hA000_0002);
      end
      fetch_stall = 1'b0;
      tick();
      check("t3_release_inst", fetch_inst, 32'hA000_0003);
      fetch_req = 1'b0;
      tick();

      // 4: 70 words without prog_last
      prog_start = 1'b1;
      tick();
      prog_start = 1'b0;
      done_cnt = 0;
      done_idx = -1;
      for (int i = 0; i < 70; i++) begin
         prog_valid = 1'b1;
         prog_data  = 32'hB000_0000 + 32'(i);
         tick();
         if (prog_done) begin
            done_cnt++;
            done_idx = i;
         end
      end
      prog_valid = 1'b0;
      check("t4_done_cnt", 32'(done_cnt), 32'd1);
      check("t4_done_idx", 32'(done_idx), 32'd63);
      check("t4_ready",    32'(prog_ready), 32'd0);
      fetch_chk("t4_mem0",  32'd0,   32'hB000_0000);
      fetch_chk("t4_mem63", 32'd252, 32'hB000_003F);

      // 5: reset in the middle of a load
      prog_start = 1'b1;
      tick();
      prog_start = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         prog_valid = 1'b1;
         prog_data  = 32'hC000_0000 + 32'(i);
         tick();
         if (prog_done) done_cnt++;
      end
      prog_data = 32'hC000_0005;
      rst       = 1'b1;
      tick();
      if (prog_done) done_cnt++;
      rst        = 1'b0;
      prog_valid = 1'b0;
      check("t5_ready", 32'(prog_ready),  32'd0);
      check("t5_valid", 32'(fetch_valid), 32'd0);
      check("t5_inst",  fetch_inst,       c_nop);
      check("t5_err",   32'(fetch_err),   32'd0);
      tick();
      if (prog_done) done_cnt++;
      check("t5_done_cnt", 32'(done_cnt), 32'd0);
      fetch_chk("t5_mem0", 32'd0,  32'hC000_0000);
      fetch_chk("t5_mem4", 32'd16, 32'hC000_0004);
      fetch_chk("t5_mem5", 32'd20, 32'hB000_0005);
      fetch_chk("t5_mem9", 32'd36, 32'hB000_0009);

      // 6: prog_start together with fetch_req (previous fetch left valid=1)
      fetch_req  = 1'b1;
      fetch_pc   = 32'd0;
      prog_start = 1'b1;
      tick();
      prog_start = 1'b0;
      fetch_req  = 1'b0;
      check("t6_valid", 32'(fetch_valid), 32'd0);
      check("t6_inst",  fetch_inst,       c_nop);
      check("t6_ready", 32'(prog_ready),  32'd1);
      // fetch requests are ignored during the load
      fetch_req  = 1'b1;
      prog_valid = 1'b1;
      prog_data  = 32'hD000_0000;
      prog_last  = 1'b1;
      tick();
      prog_valid = 1'b0;
      prog_last  = 1'b0;
      check("t6_prog_valid", 32'(fetch_valid), 32'd0);
      check("t6_done",       32'(prog_done),   32'd1);
      fetch_chk("t6_mem0", 32'd0, 32'hD000_0000);
      fetch_chk("t6_mem1", 32'd4, 32'hC000_0001);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
